// File: rtl/dsp_pkg.sv
// Shared constants and width helpers for the dsp_mac_pipe slice.
// Opmode encodings and pre-adder / product width functions.
package dsp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ACC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  function automatic int pre_w(input int bw, input int dw);
    return ((bw > dw) ? bw : dw) + 1;
  endfunction

  function automatic int prod_w(input int aw, input int bw, input int dw);
    return aw + pre_w(bw, dw);
  endfunction

endpackage

// File: rtl/dsp_post_alu.sv
// Post-adder: add/sub/acc/clear at P_W+1 bits, overflow detect, clamp.
// In: m, c, p_q, opmode. Out: p_nxt, ovf_set, ovf_clr.
import dsp_pkg::*;

module dsp_post_alu #(
  parameter int P_W = 48,
  parameter int M_W = 37,
  parameter int C_W = 48,
  parameter int SAT = 0
) (
  input  logic signed [M_W-1:0] m,
  input  logic signed [C_W-1:0] c,
  input  logic signed [P_W-1:0] p_q,
  input  logic        [1:0]     opmode,
  output logic signed [P_W-1:0] p_nxt,
  output logic                  ovf_set,
  output logic                  ovf_clr
);

  localparam logic [P_W-1:0] P_MAX = {1'b0, {(P_W-1){1'b1}}};
  localparam logic [P_W-1:0] P_MIN = {1'b1, {(P_W-1){1'b0}}};

  logic signed [P_W:0] m_x;
  logic signed [P_W:0] c_x;
  logic signed [P_W:0] p_x;
  logic signed [P_W:0] sum;
  logic                ovf;

  assign m_x = {{(P_W+1-M_W){m[M_W-1]}}, m};
  assign c_x = {{(P_W+1-C_W){c[C_W-1]}}, c};
  assign p_x = {p_q[P_W-1], p_q};

  always_comb begin
    sum = '0;
    unique case (opmode)
      OP_ADD: sum = c_x + m_x;
      OP_ACC: sum = p_x + m_x;
      OP_SUB: sum = c_x - m_x;
      OP_CLR: sum = '0;
    endcase
  end

  // Top two bits disagree: result left the signed P_W range.
  assign ovf     = sum[P_W] ^ sum[P_W-1];
  assign ovf_clr = (opmode == OP_CLR);
  assign ovf_set = ovf & ~ovf_clr;

  always_comb begin
    p_nxt = sum[P_W-1:0];
    if (SAT != 0 && ovf)
      p_nxt = sum[P_W] ? P_MIN : P_MAX;
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// 4-stage DSP slice: p = post((d +/- b) * a, c) with valid, ce, ovf.
// In: clk rst_n ce in_valid a b d c pre_sub opmode. Out: p out_valid ovf.
import dsp_pkg::*;

module dsp_mac_pipe #(
  parameter int A_W = 18,
  parameter int B_W = 18,
  parameter int D_W = 18,
  parameter int C_W = 48,
  parameter int P_W = 48,
  parameter int SAT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic signed [A_W-1:0] a,
  input  logic signed [B_W-1:0] b,
  input  logic signed [D_W-1:0] d,
  input  logic signed [C_W-1:0] c,
  input  logic                  pre_sub,
  input  logic        [1:0]     opmode,
  output logic signed [P_W-1:0] p,
  output logic                  out_valid,
  output logic                  ovf
);

  localparam int PRE_W = pre_w(B_W, D_W);
  localparam int M_W   = prod_w(A_W, B_W, D_W);

  // S1
  logic signed [A_W-1:0] a1_q;
  logic signed [B_W-1:0] b1_q;
  logic signed [D_W-1:0] d1_q;
  logic signed [C_W-1:0] c1_q;
  logic                  ps1_q;
  logic        [1:0]     op1_q;
  logic                  v1_q;
  // S2
  logic signed [PRE_W-1:0] pre_d;
  logic signed [PRE_W-1:0] pre2_q;
  logic signed [A_W-1:0]   a2_q;
  logic signed [C_W-1:0]   c2_q;
  logic        [1:0]       op2_q;
  logic                    v2_q;
  // S3
  logic signed [M_W-1:0] m_d;
  logic signed [M_W-1:0] m3_q;
  logic signed [C_W-1:0] c3_q;
  logic        [1:0]     op3_q;
  logic                  v3_q;
  // S4
  logic signed [P_W-1:0] p_d;
  logic signed [P_W-1:0] p_q;
  logic                  ovf_q;
  logic                  ov_q;
  logic                  ovf_set;
  logic                  ovf_clr;

  logic signed [PRE_W-1:0] b_x;
  logic signed [PRE_W-1:0] d_x;
  logic signed [M_W-1:0]   pre_x;
  logic signed [M_W-1:0]   a_x;

  assign b_x   = {{(PRE_W-B_W){b1_q[B_W-1]}}, b1_q};
  assign d_x   = {{(PRE_W-D_W){d1_q[D_W-1]}}, d1_q};
  assign pre_d = ps1_q ? (d_x - b_x) : (d_x + b_x);

  assign pre_x = {{A_W{pre2_q[PRE_W-1]}}, pre2_q};
  assign a_x   = {{PRE_W{a2_q[A_W-1]}}, a2_q};
  assign m_d   = pre_x * a_x;

  dsp_post_alu #(
    .P_W (P_W),
    .M_W (M_W),
    .C_W (C_W),
    .SAT (SAT)
  ) u_post (
    .m       (m3_q),
    .c       (c3_q),
    .p_q     (p_q),
    .opmode  (op3_q),
    .p_nxt   (p_d),
    .ovf_set (ovf_set),
    .ovf_clr (ovf_clr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q   <= '0;
      b1_q   <= '0;
      d1_q   <= '0;
      c1_q   <= '0;
      ps1_q  <= 1'b0;
      op1_q  <= '0;
      v1_q   <= 1'b0;
      pre2_q <= '0;
      a2_q   <= '0;
      c2_q   <= '0;
      op2_q  <= '0;
      v2_q   <= 1'b0;
      m3_q   <= '0;
      c3_q   <= '0;
      op3_q  <= '0;
      v3_q   <= 1'b0;
      p_q    <= '0;
      ovf_q  <= 1'b0;
      ov_q   <= 1'b0;
    end else if (ce) begin
      a1_q   <= a;
      b1_q   <= b;
      d1_q   <= d;
      c1_q   <= c;
      ps1_q  <= pre_sub;
      op1_q  <= opmode;
      v1_q   <= in_valid;
      pre2_q <= pre_d;
      a2_q   <= a1_q;
      c2_q   <= c1_q;
      op2_q  <= op1_q;
      v2_q   <= v1_q;
      m3_q   <= m_d;
      c3_q   <= c2_q;
      op3_q  <= op2_q;
      v3_q   <= v2_q;
      ov_q   <= v3_q;
      // Bubbles leave the accumulator and flag untouched.
      if (v3_q) begin
        p_q <= p_d;
        if (ovf_clr)
          ovf_q <= 1'b0;
        else if (ovf_set)
          ovf_q <= 1'b1;
      end
    end
  end

  assign p         = p_q;
  assign out_valid = ov_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
- Parametrised, 4-stage pipelined DSP slice: P = (D ± B) * A, followed by a post-adder.
- Post-adder modes: add C, subtract from C, accumulate into P, or clear.
- Carries a valid flag alongside the data, with a global clock enable, optional saturation and a sticky overflow flag.
- Next-generation replacement for the fixed-width DSP datapath; instantiated per channel in filter/MAC chains.

Parameters:
- A_W, 18: width of a (signed).
- B_W, 18: width of b (signed).
- D_W, 18: width of d (signed).
- C_W, 48: width of c (signed); must satisfy C_W <= P_W.
- P_W, 48: width of p and accumulator; must satisfy P_W >= A_W + max(B_W,D_W) + 1.
- SAT, 0: 1 = post-adder saturates to the signed P_W range; 0 = wraps modulo 2^P_W.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; 0 freezes every register.
- in_valid  in  1  operands valid this cycle.
- a  in  A_W  multiplier operand, signed.
- b  in  B_W  pre-adder operand, signed.
- d  in  D_W  pre-adder operand, signed.
- c  in  C_W  post-adder operand, signed.
- pre_sub  in  1  0: pre = d+b; 1: pre = d-b.
- opmode  in  2  post-adder mode: 00 ADD, 01 ACC, 10 SUB, 11 CLR.
- p  out  P_W  result, signed.
- out_valid  out  1  p holds a new result.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (async, rst_n=0): all pipeline data registers, valid bits, p, out_valid and ovf go to 0 immediately. In-flight operations are discarded. First accept is on the first rising edge with rst_n=1, ce=1, in_valid=1.
- ce=0: no register changes, including p, out_valid and ovf. in_valid is ignored. A result is delivered on each rising edge where ce=1 and out_valid=1.
- S1 (ce=1): register a, b, d, c, pre_sub, opmode and v1 <= in_valid.
- S2: pre = sext(d) ± sext(b), PRE_W = max(B_W,D_W)+1, never overflows. Register with a_d, c_d, opmode_d and v2.
- S3: m = pre * a, signed full width A_W + PRE_W. Register with c_dd, opmode_dd and v3.
- S4: when v3=1, compute at P_W+1 bits with m and c sign-extended to P_W:
  - ADD: p <= c + m.
  - ACC: p <= p + m, using the current p register, so back-to-back ACC operations chain correctly.
  - SUB: p <= c - m.
  - CLR: p <= 0 and ovf <= 0.
- S4 overflow: if the P_W+1 result is outside the signed P_W range, ovf <= 1 (sticky until reset or CLR).
  - SAT=1: p clamps to +2^(P_W-1)-1 or -2^(P_W-1).
  - SAT=0: p takes the low P_W bits.
- S4 hold: when v3=0, p holds. Bubbles never disturb the accumulator.
- Latency and throughput:
  - out_valid <= v3 on every ce=1 edge.
  - Latency is 4 ce-enabled edges from acceptance to out_valid=1 with p updated.
  - Throughput is 1 per cycle. out_valid is high for exactly one ce-high cycle per accepted input.
- Data registers in S1–S3 may load on invalid cycles; only the valid bits and p/ovf are gated by valid.
- Simultaneous CLR and overflow: CLR wins (ovf=0).

Decomposition:
- Shared package dsp_pkg:
  - opmode localparams OP_ADD=2'b00, OP_ACC=2'b01, OP_SUB=2'b10, OP_CLR=2'b11.
  - constant function for pre-adder/product width.
- One sub-module, dsp_post_alu: combinational P_W+1 add/sub/acc/clear, overflow detect and SAT clamp. Ports: m, c, p_q, opmode → p_nxt, ovf_set, ovf_clr.
- Pipeline registers stay in dsp_mac_pipe.

Test Plan:
- Basic ADD: after reset, ce=1; a=3, b=2, d=5, c=10, pre_sub=0, opmode=ADD, one valid cycle.
  - Exactly 4 edges later: out_valid=1, p=31.
  - Next cycle: out_valid=0.
- Pre-subtract and SUB: a=3, b=2, d=5, pre_sub=1, c=100, opmode=SUB → p=91, ovf=0.
- Negative operands: a=18'h3FFFF (-1), b=0, d=4, c=0, ADD → p=48'hFFFF_FFFF_FFFC (-4).
- Accumulate with bubble: CLR, then ACC with a=2, b=1, d=2 (m=6) on three valid inputs with one in_valid=0 gap.
  - Results in order: p=0, 6, 12, 18.
  - p unchanged during the bubble cycle.
- ce stall: 4 back-to-back ADD inputs with c=1, 2, 3, 4 and m=0; drop ce for 3 cycles mid-flight.
  - p and out_valid frozen during the stall.
  - Results 1, 2, 3, 4 delivered in order with no loss or duplication.
- Overflow and reset: c=48'h7FFF_FFFF_FFFF, m=1, ADD.
  - SAT=0: p=48'h8000_0000_0000, ovf=1, and ovf stays 1 on later ADDs.
  - SAT=1: p=48'h7FFF_FFFF_FFFF, ovf=1.
  - Assert rst_n=0 mid-pipeline: p=0, out_valid=0 and ovf=0 immediately; no stale result emerges after release.
